alu_req_sequencer: RTL and testbench

- Two-requester front-end for the 16-bit multi-cycle ALU.
- Arbitrates round-robin between two clients and latches the winner's opcode and operands.
- Sequences the ALU: start pulse, operand A then operand B on the ALU inbus, wait for finish, capture result and flags.
- Returns the result to the requester with a one-cycle done pulse; a watchdog aborts hung operations by resetting the ALU.

---
 rtl/alu_req_sequencer.sv | 172 +++++++++++++++++
 tb/tb_alu_req_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_sequencer.sv
// Two-client round-robin front-end for the multi-cycle 16-bit ALU: grants one request,
// sequences start/operand A/operand B, waits for finish (with watchdog) and returns the result.
module alu_req_sequencer #(
  parameter int A_HOLD  = 2,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req0,
  input  logic [3:0]  op0,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  output logic        gnt0,
  output logic        done0,
  input  logic        req1,
  input  logic [3:0]  op1,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  output logic        gnt1,
  output logic        done1,
  output logic [15:0] rdata,
  output logic [3:0]  rflags,
  output logic        err,
  output logic        busy,
  output logic        alu_start,
  output logic [3:0]  alu_s,
  output logic [15:0] alu_inbus,
  input  logic [15:0] alu_outbus,
  input  logic        alu_negative,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_overflow,
  input  logic        alu_finish,
  output logic        alu_rst_b
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_HOLD_A, S_DRIVE_B, S_WAIT, S_CAPTURE, S_DONE, S_ABORT
  } state_e;

  localparam logic [2:0] HOLD_LAST = 3'((A_HOLD > 1) ? A_HOLD - 2 : 0);
  localparam logic [9:0] TO_LAST   = 10'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        prio_q, prio_d;
  logic        owner_q, owner_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] a_q, a_d, b_q, b_d;
  logic [2:0]  hold_q, hold_d;
  logic [9:0]  wdog_q, wdog_d;
  logic        grant, sel;

  logic        gnt0_q, gnt1_q, done0_q, done1_q, err_q, busy_q, start_q, abort_n_q;
  logic [3:0]  alu_s_q, rflags_q;
  logic [15:0] inbus_q, rdata_q;

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    owner_d = owner_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    grant   = 1'b0;
    sel     = 1'b0;
    hold_d  = (state_q == S_HOLD_A) ? hold_q + 3'd1 : 3'd0;
    wdog_d  = (state_q == S_WAIT) ? wdog_q + 10'd1 : 10'd0;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          grant   = 1'b1;
          // prio_q names the client that wins a tie; it flips to the other after each grant
          sel     = (req0 && req1) ? prio_q : req1;
          owner_d = sel;
          prio_d  = ~sel;
          op_d    = sel ? op1 : op0;
          a_d     = sel ? a1 : a0;
          b_d     = sel ? b1 : b0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE:   state_d = (A_HOLD == 1) ? S_DRIVE_B : S_HOLD_A;
      S_HOLD_A:  if (hold_q == HOLD_LAST) state_d = S_DRIVE_B;
      S_DRIVE_B: state_d = S_WAIT;
      S_WAIT: begin
        if (alu_finish)              state_d = S_CAPTURE;
        else if (wdog_q == TO_LAST)  state_d = S_ABORT;
      end
      S_CAPTURE: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      S_ABORT:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      prio_q  <= 1'b0;
      owner_q <= 1'b0;
      hold_q  <= 3'd0;
      wdog_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      wdog_q  <= wdog_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q <= op_d;
    a_q  <= a_d;
    b_q  <= b_d;
  end

  // Outputs are registered from the next state so each one is valid during the state it belongs to.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      abort_n_q <= 1'b1;
      alu_s_q   <= 4'd0;
      inbus_q   <= 16'd0;
      rdata_q   <= 16'd0;
      rflags_q  <= 4'd0;
    end else begin
      gnt0_q    <= grant && !sel;
      gnt1_q    <= grant && sel;
      done0_q   <= (state_d == S_DONE || state_d == S_ABORT) && !owner_q;
      done1_q   <= (state_d == S_DONE || state_d == S_ABORT) && owner_q;
      busy_q    <= (state_d != S_IDLE);
      start_q   <= (state_d == S_ISSUE);
      abort_n_q <= (state_d != S_ABORT);
      if (state_d == S_DONE)       err_q <= 1'b0;
      else if (state_d == S_ABORT) err_q <= 1'b1;
      if (grant) begin
        alu_s_q <= op_d;
        inbus_q <= a_d;
      end else if (state_d == S_DRIVE_B) begin
        inbus_q <= b_q;
      end
      if (state_q == S_CAPTURE) begin
        rdata_q  <= alu_outbus;
        rflags_q <= {alu_negative, alu_zero, alu_carry, alu_overflow};
      end else if (state_d == S_ABORT) begin
        rdata_q  <= 16'd0;
        rflags_q <= 4'd0;
      end
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign alu_start = start_q;
  assign alu_s     = alu_s_q;
  assign alu_inbus = inbus_q;
  assign rdata     = rdata_q;
  assign rflags    = rflags_q;
  assign alu_rst_b = rst_b & abort_n_q;

endmodule

// File: tb/tb_alu_req_sequencer.sv
// Scoreboard bench for alu_req_sequencer: a behavioural ALU answers the main instance,
// a second instance with A_HOLD=1 is driven cycle by cycle.
module tb_alu_req_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_b;
  logic        req0, req1, gnt0, gnt1, done0, done1, err, busy, alu_start, alu_rst_b;
  logic [3:0]  op0, op1, rflags, alu_s;
  logic [15:0] a0, b0, a1, b1, rdata, alu_inbus, alu_outbus;
  logic        alu_negative, alu_zero, alu_carry, alu_overflow, alu_finish;

  logic        req_h, gnt_h0, gnt_h1, done_h0, done_h1, err_h, busy_h, start_h, rst_b_h, fin_h;
  logic [3:0]  op_h, rflags_h, s_h;
  logic [15:0] a_h, b_h, rdata_h, inbus_h, outbus_h;

  alu_req_sequencer #(.A_HOLD(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
    .rdata(rdata), .rflags(rflags), .err(err), .busy(busy),
    .alu_start(alu_start), .alu_s(alu_s), .alu_inbus(alu_inbus), .alu_outbus(alu_outbus),
    .alu_negative(alu_negative), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_finish(alu_finish), .alu_rst_b(alu_rst_b)
  );

  alu_req_sequencer #(.A_HOLD(1), .TIMEOUT(8)) dut_h (
    .clk(clk), .rst_b(rst_b),
    .req0(req_h), .op0(op_h), .a0(a_h), .b0(b_h), .gnt0(gnt_h0), .done0(done_h0),
    .req1(1'b0), .op1(4'd0), .a1(16'd0), .b1(16'd0), .gnt1(gnt_h1), .done1(done_h1),
    .rdata(rdata_h), .rflags(rflags_h), .err(err_h), .busy(busy_h),
    .alu_start(start_h), .alu_s(s_h), .alu_inbus(inbus_h), .alu_outbus(outbus_h),
    .alu_negative(1'b0), .alu_zero(1'b0), .alu_carry(1'b0),
    .alu_overflow(1'b0), .alu_finish(fin_h), .alu_rst_b(rst_b_h)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic        cl;
    logic        er;
    logic [15:0] rd;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb_q[$];
  int   gq[$];

  // Behavioural ALU for the A_HOLD=2 instance: finish rises in WAIT cycle index fin_lat.
  int          fin_lat = -1;
  int          m_cnt = 0;
  int          fin_cyc = -100;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b, m_r;
  logic [16:0] m_sum;

  always @(negedge clk) begin
    alu_finish = 1'b0;
    if (!alu_rst_b) m_cnt = 0;
    else if (alu_start) begin
      m_cnt = 1;
      m_op  = alu_s;
      m_a   = alu_inbus;
    end else if (m_cnt > 0) m_cnt++;
    if (m_cnt == 3) begin
      m_b   = alu_inbus;
      m_sum = {1'b0, m_a} + {1'b0, m_b};
      alu_carry    = 1'b0;
      alu_overflow = 1'b0;
      case (m_op)
        4'h0: begin
          m_r = m_sum[15:0];
          alu_carry    = m_sum[16];
          alu_overflow = (m_a[15] == m_b[15]) && (m_r[15] != m_a[15]);
        end
        4'h2:    m_r = m_a & m_b;
        4'h3:    m_r = m_a ^ m_b;
        default: m_r = m_a;
      endcase
      alu_outbus   = m_r;
      alu_negative = m_r[15];
      alu_zero     = (m_r == 16'd0);
    end
    if (m_cnt > 0 && fin_lat >= 0 && m_cnt == 4 + fin_lat) begin
      alu_finish = 1'b1;
      fin_cyc    = cyc;
    end
  end

  // Monitor: pops expected grants and completions as the main instance presents them.
  always @(negedge clk) begin
    if (rst_b) begin
      if (gnt0 || gnt1) begin
        chk("gnt_onehot", {31'd0, gnt0 & gnt1}, 32'd0);
        if (gq.size() == 0) begin
          n_chk++;
          $display("FAIL gnt_unexpected: got gnt0=%0b gnt1=%0b, expected no grant", gnt0, gnt1);
        end else chk("gnt_order", {31'd0, gnt1}, gq.pop_front());
      end
      if (done0 || done1) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          $display("FAIL done_unexpected: got done0=%0b done1=%0b, expected none", done0, done1);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("done_client", {31'd0, done1}, {31'd0, e.cl});
          chk("done_err", {31'd0, err}, {31'd0, e.er});
          chk("done_rdata", {16'd0, rdata}, {16'd0, e.rd});
          chk("done_rflags", {28'd0, rflags}, {28'd0, e.fl});
          if (!e.er) chk("done_latency", cyc - fin_cyc, 2);
        end
      end
    end
  end

  task automatic wait_gnt0(input int budget, output int gcyc);
    int k = 0;
    do begin @(negedge clk); k++; end while (!gnt0 && k < budget);
    gcyc = cyc;
    if (!gnt0) begin
      n_chk++;
      $display("FAIL wait_gnt0: got no grant, expected one within %0d cycles", budget);
    end
  endtask

  task automatic wait_done(input logic cl, input int budget);
    int k = 0;
    do begin @(negedge clk); k++; end while (!(cl ? done1 : done0) && k < budget);
    if (!(cl ? done1 : done0)) begin
      n_chk++;
      $display("FAIL wait_done%0d: got no done, expected one within %0d cycles", cl, budget);
    end
  endtask

  function automatic exp_t mk(input logic cl, input logic er, input logic [15:0] rd, input logic [3:0] fl);
    exp_t e;
    e.cl = cl; e.er = er; e.rd = rd; e.fl = fl;
    return e;
  endfunction

  initial begin
    int g, n0, n1, k;
    rst_b = 1'b0;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    req_h = 0; op_h = 0; a_h = 0; b_h = 0; fin_h = 0; outbus_h = 0;
    alu_outbus = 0; alu_negative = 0; alu_zero = 0; alu_carry = 0; alu_overflow = 0;
    repeat (2) @(negedge clk);
    chk("rst_alu_rst_b", {31'd0, alu_rst_b}, 0);
    chk("rst_ctrl", {26'd0, gnt0, gnt1, done0, done1, err, alu_start}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_data", {rdata, alu_inbus}, 0);
    chk("rst_s_flags", {24'd0, alu_s, rflags}, 0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rel_alu_rst_b", {31'd0, alu_rst_b}, 1);

    // Reset in the middle of WAIT: operation discarded, no done
    fin_lat = -1;
    gq.push_back(0);
    op0 = 4'h0; a0 = 16'h0009; b0 = 16'h0001; req0 = 1;
    repeat (6) @(negedge clk);
    chk("wait_busy", {31'd0, busy}, 1);
    chk("wait_inbus_b", {16'd0, alu_inbus}, 32'h0001);
    #2 rst_b = 1'b0; req0 = 0;
    #1;
    chk("midrst_alu_rst_b", {31'd0, alu_rst_b}, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    chk("midrst_inbus", {16'd0, alu_inbus}, 0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_busy", {31'd0, busy}, 0);
    chk("post_alu_rst_b", {31'd0, alu_rst_b}, 1);
    chk("post_done", {30'd0, done0, done1}, 0);

    // Contention: both clients held high, grants alternate starting with client 0
    fin_lat = 2;
    gq.push_back(0); gq.push_back(1); gq.push_back(0); gq.push_back(1);
    sb_q.push_back(mk(0, 0, 16'h0000, 4'h6));
    sb_q.push_back(mk(1, 0, 16'h8000, 4'h9));
    sb_q.push_back(mk(0, 0, 16'h00F0, 4'h0));
    sb_q.push_back(mk(1, 0, 16'h0000, 4'h4));
    op0 = 4'h0; a0 = 16'hFFFF; b0 = 16'h0001;
    op1 = 4'h0; a1 = 16'h7FFF; b1 = 16'h0001;
    req0 = 1; req1 = 1;
    n0 = 0; n1 = 0; k = 0;
    while ((n0 < 2 || n1 < 2) && k < 200) begin
      @(negedge clk);
      k++;
      if (done0) begin
        n0++;
        if (n0 == 1) begin op0 = 4'h2; a0 = 16'hF0F0; b0 = 16'h0FF0; end
        else req0 = 0;
      end
      if (done1) begin
        n1++;
        if (n1 == 1) begin op1 = 4'h3; a1 = 16'h1234; b1 = 16'h1234; end
        else req1 = 0;
      end
    end
    if (n0 < 2 || n1 < 2) begin
      n_chk++;
      $display("FAIL contention_done_count: got %0d/%0d, expected 2/2", n0, n1);
      req0 = 0; req1 = 0;
    end

    // Single request: start pulse, A for two cycles, then B; done two cycles after finish
    fin_lat = 3;
    gq.push_back(0);
    sb_q.push_back(mk(0, 0, 16'h0008, 4'h0));
    op0 = 4'h0; a0 = 16'h0003; b0 = 16'h0005; req0 = 1;
    wait_gnt0(10, g);
    chk("issue_start", {31'd0, alu_start}, 1);
    chk("issue_inbus", {16'd0, alu_inbus}, 32'h0003);
    chk("issue_s", {28'd0, alu_s}, 0);
    @(negedge clk);
    chk("hold_start", {31'd0, alu_start}, 0);
    chk("hold_inbus", {16'd0, alu_inbus}, 32'h0003);
    @(negedge clk);
    chk("drive_b_inbus", {16'd0, alu_inbus}, 32'h0005);
    wait_done(0, 40);
    req0 = 0;

    // Timeout: no finish, ABORT eight cycles after WAIT entry
    fin_lat = -1;
    gq.push_back(0);
    sb_q.push_back(mk(0, 1, 16'h0000, 4'h0));
    op0 = 4'h0; a0 = 16'h1234; b0 = 16'h1111; req0 = 1;
    wait_gnt0(10, g);
    wait_done(0, 40);
    req0 = 0;
    chk("abort_cycle", cyc - g, 11);
    chk("abort_alu_rst_b", {31'd0, alu_rst_b}, 0);
    @(negedge clk);
    chk("abort_rst_release", {31'd0, alu_rst_b}, 1);
    chk("abort_err_hold", {31'd0, err}, 1);
    chk("abort_done_pulse", {31'd0, done0}, 0);

    // Finish on the same cycle the watchdog expires: capture wins
    fin_lat = 7;
    gq.push_back(0);
    sb_q.push_back(mk(0, 0, 16'h0123, 4'h0));
    op0 = 4'h0; a0 = 16'h0100; b0 = 16'h0023; req0 = 1;
    wait_done(0, 40);
    req0 = 0;

    // A_HOLD=1 instance: B right after start; stray finish in IDLE and ISSUE ignored
    @(negedge clk);
    op_h = 4'h2; a_h = 16'hAAAA; b_h = 16'h5555; req_h = 1; fin_h = 1;
    @(negedge clk);
    chk("h1_gnt", {31'd0, gnt_h0}, 1);
    chk("h1_start", {31'd0, start_h}, 1);
    chk("h1_inbus_a", {16'd0, inbus_h}, 32'hAAAA);
    @(negedge clk);
    fin_h = 0;
    chk("h1_start_low", {31'd0, start_h}, 0);
    chk("h1_inbus_b", {16'd0, inbus_h}, 32'h5555);
    @(negedge clk);
    chk("h1_wait_busy", {31'd0, busy_h}, 1);
    chk("h1_wait_nodone", {31'd0, done_h0}, 0);
    @(negedge clk);
    chk("h1_wait2_nodone", {31'd0, done_h0}, 0);
    fin_h = 1; outbus_h = 16'h1357;
    @(negedge clk);
    fin_h = 0;
    chk("h1_capture_nodone", {31'd0, done_h0}, 0);
    @(negedge clk);
    chk("h1_done", {31'd0, done_h0}, 1);
    chk("h1_rdata", {16'd0, rdata_h}, 32'h1357);
    chk("h1_err", {31'd0, err_h}, 0);
    req_h = 0;
    @(negedge clk);
    chk("h1_idle", {31'd0, busy_h}, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    chk("gq_empty", gq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
